// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-ported register file with clear sequencer:
// clear-FSM state encoding, read-port ceiling and the address range check.
package regfile_pkg;

    // Clear sequencer state encoding
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    // Largest supported number of read ports
    localparam int unsigned RF_MAX_RD = 8;

    // Unsigned inclusive range check; callers widen their address to 32 bits
    function automatic logic in_range(input logic [31:0] addr,
                                      input int unsigned lo_v,
                                      input int unsigned hi_v);
        return (addr >= lo_v) && (addr <= hi_v);
    endfunction

endpackage

// File: rtl/regfile_clr_fsm.sv
// Clear sequencer: walks ptr from lo to hi writing one word per cycle after
// reset or a CLR request, and reports BUSY while it owns the array.
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int unsigned lo         = 0,
    parameter int unsigned hi         = 31,
    parameter int unsigned addr_width = 5
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CLR,
    output logic                  BUSY,
    output logic                  clr_we,
    output logic [addr_width-1:0] clr_addr
);

    localparam logic [addr_width-1:0] LO_A = addr_width'(lo);
    localparam logic [addr_width-1:0] HI_A = addr_width'(hi);

    logic [0:0]            state_q;
    logic [0:0]            state_d;
    logic [addr_width-1:0] ptr_q;
    logic [addr_width-1:0] ptr_d;

    // Next-state logic; a CLR during a clear restarts the walk from lo
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == ST_CLEAR) begin
            if (CLR) begin
                ptr_d = LO_A;
            end else if (ptr_q == HI_A) begin
                state_d = ST_IDLE;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end else if (CLR) begin
            state_d = ST_CLEAR;
            ptr_d   = LO_A;
        end
    end

    // State and pointer registers; reset always launches a fresh clear
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_CLEAR;
            ptr_q   <= LO_A;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign BUSY     = (state_q == ST_CLEAR);
    // No array write in a cycle where reset is being sampled
    assign clr_we   = (state_q == ST_CLEAR) && !RST;
    assign clr_addr = ptr_q;

endmodule

// File: rtl/regfile_mp_clr.sv
// Multi-ported register file: one write port, n_rd registered read ports,
// hardware clear sequencer and sticky out-of-range / dropped-write flags.
// Define REGFILE_BYPASS_EN for write-first collision behaviour; by default a
// read of the address being written returns the old contents (read-first).
module regfile_mp_clr
    import regfile_pkg::*;
#(
    parameter int unsigned           addr_width = 5,
    parameter int unsigned           data_width = 32,
    parameter int unsigned           lo         = 0,
    parameter int unsigned           hi         = 31,
    parameter int unsigned           n_rd       = 4,
    parameter logic [data_width-1:0] init_val   = '0
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [addr_width-1:0]        ADDR_IN,
    input  logic [data_width-1:0]        D_IN,
    input  logic                         WE,
    input  logic [n_rd*addr_width-1:0]   ADDR_RD,
    output logic [n_rd*data_width-1:0]   D_OUT,
    input  logic                         CLR,
    output logic                         BUSY,
    output logic                         ERR_OOR,
    output logic                         WDROP
);

    localparam int unsigned           DEPTH = hi - lo + 1;
    localparam int unsigned           IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [addr_width-1:0] LO_A  = addr_width'(lo);

    // Storage is sized to lo..hi only; addresses are rebased to zero
    function automatic logic [IDX_W-1:0] to_idx(input logic [addr_width-1:0] a);
        logic [addr_width-1:0] off;
        off = a - LO_A;
        return off[IDX_W-1:0];
    endfunction

    logic                  clr_we;
    logic [addr_width-1:0] clr_addr;
    logic                  wr_in_range;
    logic                  user_we_ok;
    logic                  wr_oor;
    logic                  clr_accept;
    logic                  wdrop_set;
    logic                  err_set;
    logic [n_rd-1:0]       rd_oor;
    logic                  mem_we;
    logic [IDX_W-1:0]      mem_widx;
    logic [data_width-1:0] mem_wdata;
    logic                  err_oor_q;
    logic                  wdrop_q;

    logic [data_width-1:0] mem_q [DEPTH];

    regfile_clr_fsm #(
        .lo         (lo),
        .hi         (hi),
        .addr_width (addr_width)
    ) u_clr_fsm (
        .CLK      (CLK),
        .RST      (RST),
        .CLR      (CLR),
        .BUSY     (BUSY),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign wr_in_range = in_range(32'(ADDR_IN), lo, hi);
    // CLR wins over a simultaneous user write, and the sequencer owns the
    // array while BUSY, so user writes are only taken in a quiet IDLE cycle
    assign user_we_ok  = WE && !BUSY && !CLR && !RST && wr_in_range;
    assign wr_oor      = WE && !BUSY && !CLR && !wr_in_range;
    assign wdrop_set   = WE && (BUSY || CLR);
    assign clr_accept  = CLR && !BUSY;
    assign err_set     = wr_oor || (|rd_oor);

    // Single physical write port shared by sequencer and user; the two
    // sources are mutually exclusive because user writes require !BUSY
    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = '0;
        mem_wdata = '0;
        if (clr_we) begin
            mem_we    = 1'b1;
            mem_widx  = to_idx(clr_addr);
            mem_wdata = init_val;
        end else if (user_we_ok) begin
            mem_we    = 1'b1;
            mem_widx  = to_idx(ADDR_IN);
            mem_wdata = D_IN;
        end
    end

    // Array write; contents are defined by the clear sequencer, not reset
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[mem_widx] <= mem_wdata;
        end
    end

    // Sticky flags; a new event in the same cycle beats an accepted CLR
    always_ff @(posedge CLK) begin
        if (RST) begin
            err_oor_q <= 1'b0;
            wdrop_q   <= 1'b0;
        end else begin
            if (err_set) begin
                err_oor_q <= 1'b1;
            end else if (clr_accept) begin
                err_oor_q <= 1'b0;
            end
            if (wdrop_set) begin
                wdrop_q <= 1'b1;
            end else if (clr_accept) begin
                wdrop_q <= 1'b0;
            end
        end
    end

    assign ERR_OOR = err_oor_q;
    assign WDROP   = wdrop_q;

    // Read ports: one registered output per port, up to the package ceiling
    for (genvar gi = 0; gi < RF_MAX_RD; gi++) begin : g_rd
        if (gi < n_rd) begin : g_port
            logic [addr_width-1:0] raddr;
            logic                  raddr_ok;
            logic                  hit;
            logic [data_width-1:0] dout_q;

            assign raddr    = ADDR_RD[gi*addr_width +: addr_width];
            assign raddr_ok = in_range(32'(raddr), lo, hi);
            assign rd_oor[gi] = !BUSY && !raddr_ok;
`ifdef REGFILE_BYPASS_EN
            assign hit = user_we_ok && (ADDR_IN == raddr);
`else
            assign hit = 1'b0;
`endif

            // Registered read with clear/out-of-range substitution and bypass
            always_ff @(posedge CLK) begin
                if (RST) begin
                    dout_q <= '0;
                end else if (BUSY || !raddr_ok) begin
                    dout_q <= init_val;
                end else if (hit) begin
                    dout_q <= D_IN;
                end else begin
                    dout_q <= mem_q[to_idx(raddr)];
                end
            end

            assign D_OUT[gi*data_width +: data_width] = dout_q;
        end
    end

endmodule

// File: tb/tb_regfile_mp_clr.sv
// Directed bench for regfile_mp_clr: a 16-entry instance (lo=0, hi=15) and a
// 13-entry instance (hi=12) for out-of-range checks; read expectations are
// queued when addresses are driven and compared after the capturing edge.
module tb_regfile_mp_clr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: lo=0, hi=15
    logic        rst_a, we_a, clr_a;
    logic [3:0]  addr_in_a;
    logic [7:0]  d_in_a;
    logic [7:0]  addr_rd_a;
    logic [15:0] dout_a;
    logic        busy_a, err_a, wdrop_a;

    // Instance B: lo=0, hi=12
    logic        rst_b, we_b, clr_b;
    logic [3:0]  addr_in_b;
    logic [7:0]  d_in_b;
    logic [7:0]  addr_rd_b;
    logic [15:0] dout_b;
    logic        busy_b, err_b, wdrop_b;

    regfile_mp_clr #(
        .addr_width (4), .data_width (8), .lo (0), .hi (15),
        .n_rd (2), .init_val (8'hAA)
    ) u_dut_a (
        .CLK (clk), .RST (rst_a), .ADDR_IN (addr_in_a), .D_IN (d_in_a),
        .WE (we_a), .ADDR_RD (addr_rd_a), .D_OUT (dout_a), .CLR (clr_a),
        .BUSY (busy_a), .ERR_OOR (err_a), .WDROP (wdrop_a)
    );

    regfile_mp_clr #(
        .addr_width (4), .data_width (8), .lo (0), .hi (12),
        .n_rd (2), .init_val (8'hAA)
    ) u_dut_b (
        .CLK (clk), .RST (rst_b), .ADDR_IN (addr_in_b), .D_IN (d_in_b),
        .WE (we_b), .ADDR_RD (addr_rd_b), .D_OUT (dout_b), .CLR (clr_b),
        .BUSY (busy_b), .ERR_OOR (err_b), .WDROP (wdrop_b)
    );

    typedef struct {
        string      tag;
        int         src;
        logic [7:0] exp;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] model_a [16];
    int         checks   = 0;
    int         failures = 0;
    int         n;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] out_of(input int src);
        case (src)
            0:       return dout_a[7:0];
            1:       return dout_a[15:8];
            2:       return dout_b[7:0];
            default: return dout_b[15:8];
        endcase
    endfunction

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.tag, 32'(out_of(e.src)), 32'(e.exp));
        end
    endtask

    // One A cycle: drive reads (and optionally a write), queue expectations, compare
    task automatic rd_a(input string tag, input logic [3:0] a0, input logic [3:0] a1,
                        input logic we, input logic [3:0] wa, input logic [7:0] wd);
        exp_t e0, e1;
        addr_rd_a = {a1, a0};
        we_a      = we;
        addr_in_a = wa;
        d_in_a    = wd;
        e0.tag = {tag, "_p0"}; e0.src = 0; e0.exp = model_a[a0];
        e1.tag = {tag, "_p1"}; e1.src = 1; e1.exp = model_a[a1];
`ifdef REGFILE_BYPASS_EN
        if (we && wa == a0) e0.exp = wd;
        if (we && wa == a1) e1.exp = wd;
`endif
        sb_q.push_back(e0);
        sb_q.push_back(e1);
        step();
        we_a = 1'b0;
        if (we) model_a[wa] = wd;
        $display("A %s a0=%0d a1=%0d we=%0b d0=%h d1=%h", tag, a0, a1, we, dout_a[7:0], dout_a[15:8]);
        drain();
    endtask

    task automatic rd_b(input string tag, input logic [3:0] a0, input logic [3:0] a1,
                        input logic [7:0] x0, input logic [7:0] x1);
        exp_t e0, e1;
        addr_rd_b = {a1, a0};
        e0.tag = {tag, "_p0"}; e0.src = 2; e0.exp = x0;
        e1.tag = {tag, "_p1"}; e1.src = 3; e1.exp = x1;
        sb_q.push_back(e0);
        sb_q.push_back(e1);
        step();
        $display("B %s a0=%0d a1=%0d d0=%h d1=%h", tag, a0, a1, dout_b[7:0], dout_b[15:8]);
        drain();
    endtask

    task automatic wait_idle_a(input int max, output int cnt);
        cnt = 0;
        while (busy_a && cnt < max) begin
            step();
            cnt++;
        end
    endtask

    task automatic wait_idle_b(input int max, output int cnt);
        cnt = 0;
        while (busy_b && cnt < max) begin
            step();
            cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1; we_a = 1'b0; clr_a = 1'b0; addr_in_a = '0; d_in_a = '0; addr_rd_a = '0;
        rst_b = 1'b1; we_b = 1'b0; clr_b = 1'b0; addr_in_b = '0; d_in_b = '0; addr_rd_b = '0;
        for (int i = 0; i < 16; i++) model_a[i] = 8'hAA;

        // Reset state
        step();
        chk("a_rst_busy",  32'(busy_a),  32'd1);
        chk("a_rst_dout",  32'(dout_a),  32'd0);
        chk("a_rst_err",   32'(err_a),   32'd0);
        chk("a_rst_wdrop", 32'(wdrop_a), 32'd0);
        rst_a = 1'b0;
        wait_idle_a(40, n);
        $display("A reset clear busy_cycles=%0d", n);
        chk("a_clear_len", 32'(n), 32'd16);

        // Every entry holds init_val after the clear
        for (int i = 0; i < 16; i++) rd_a("a_init", 4'(i), 4'(15 - i), 1'b0, 4'd0, 8'h00);

        // Write then read
        rd_a("a_wr5", 4'd0, 4'd1, 1'b1, 4'd5, 8'h3C);
        rd_a("a_rd5", 4'd5, 4'd6, 1'b0, 4'd0, 8'h00);

        // Collision: write and read address 9 in the same cycle
        rd_a("a_coll",  4'd9, 4'd3, 1'b1, 4'd9, 8'h77);
        rd_a("a_coll2", 4'd9, 4'd9, 1'b0, 4'd0, 8'h00);
        chk("a_err_idle",   32'(err_a),   32'd0);
        chk("a_wdrop_idle", 32'(wdrop_a), 32'd0);

        // Dropped write while the clear sequencer is busy
        clr_a = 1'b1; step(); clr_a = 1'b0;
        $display("A clr busy=%0b", busy_a);
        chk("a_clr_busy", 32'(busy_a), 32'd1);
        we_a = 1'b1; addr_in_a = 4'd2; d_in_a = 8'h11; step(); we_a = 1'b0;
        $display("A busy write wdrop=%0b", wdrop_a);
        chk("a_wdrop_set", 32'(wdrop_a), 32'd1);
        wait_idle_a(40, n);
        chk("a_clr_len", 32'(n), 32'd15);
        chk("a_wdrop_sticky", 32'(wdrop_a), 32'd1);
        for (int i = 0; i < 16; i++) model_a[i] = 8'hAA;
        rd_a("a_drop_rd", 4'd2, 4'd5, 1'b0, 4'd0, 8'h00);
        rd_a("a_drop_rd9", 4'd9, 4'd15, 1'b0, 4'd0, 8'h00);

        // Accepted CLR clears the sticky flag
        clr_a = 1'b1; step(); clr_a = 1'b0;
        $display("A clr flags wdrop=%0b", wdrop_a);
        chk("a_clr_flags", 32'(wdrop_a), 32'd0);
        wait_idle_a(40, n);
        chk("a_clr_len2", 32'(n), 32'd16);

        // CLR and WE together in IDLE: CLR wins, write dropped
        clr_a = 1'b1; we_a = 1'b1; addr_in_a = 4'd3; d_in_a = 8'h66;
        step();
        clr_a = 1'b0; we_a = 1'b0;
        $display("A clr+we wdrop=%0b busy=%0b", wdrop_a, busy_a);
        chk("a_clrwe_wdrop", 32'(wdrop_a), 32'd1);

        // Reset in the middle of the clear (ptr reaches 7 after 7 edges)
        for (int i = 0; i < 7; i++) step();
        rst_a = 1'b1; step(); rst_a = 1'b0;
        chk("a_mid_busy",  32'(busy_a),  32'd1);
        chk("a_mid_wdrop", 32'(wdrop_a), 32'd0);
        wait_idle_a(40, n);
        $display("A mid-clear reset busy_cycles=%0d", n);
        chk("a_mid_len", 32'(n), 32'd16);
        rd_a("a_mid_rd", 4'd3, 4'd9, 1'b0, 4'd0, 8'h00);

        // Instance B: out-of-range behaviour with hi=12
        rst_b = 1'b0;
        wait_idle_b(40, n);
        chk("b_clear_len", 32'(n), 32'd13);
        chk("b_err_init",  32'(err_b), 32'd0);
        we_b = 1'b1; addr_in_b = 4'd14; d_in_b = 8'h55; step(); we_b = 1'b0;
        $display("B oor write err=%0b wdrop=%0b", err_b, wdrop_b);
        chk("b_wr_oor_err",   32'(err_b),   32'd1);
        chk("b_wr_oor_wdrop", 32'(wdrop_b), 32'd0);
        rd_b("b_rd13", 4'd13, 4'd12, 8'hAA, 8'hAA);
        chk("b_err_held", 32'(err_b), 32'd1);
        we_b = 1'b1; addr_in_b = 4'd12; d_in_b = 8'h42; step(); we_b = 1'b0;
        rd_b("b_rd12", 4'd12, 4'd14, 8'h42, 8'hAA);
        addr_rd_b = 8'h00;
        clr_b = 1'b1; step(); clr_b = 1'b0;
        $display("B clr err=%0b", err_b);
        chk("b_clr_err", 32'(err_b), 32'd0);
        wait_idle_b(40, n);
        chk("b_clear_len2", 32'(n), 32'd13);
        chk("b_err_quiet",  32'(err_b), 32'd0);
        rd_b("b_rd15", 4'd15, 4'd12, 8'hAA, 8'hAA);
        chk("b_rd_oor_err", 32'(err_b), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_mp_clr.md
# regfile_mp_clr

Parametrised multi-ported register file with registered read ports, configurable read-port count, a hardware clear sequencer and out-of-range detection. It is the successor to the combinational five-read-port register file, for Bluespec-generated designs that need synthesizable reset-to-known contents, timing-friendly registered reads and a defined write/read collision rule. It sits between BSV-generated module logic and the storage array, behind the same write-port/read-port method interface.

## Interface
- addr_width, 5: address width.
- data_width, 32: word width.
- lo, 0: lowest valid index.
- hi, 31: highest valid index; requires lo <= hi < 2**addr_width.
- n_rd, 4: read-port count, 1..8.
- init_val, 0: data_width-wide value written by the clear sequencer.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- ADDR_IN  in  addr_width  write address.
- D_IN  in  data_width  write data.
- WE  in  1  write enable.
- ADDR_RD  in  n_rd*addr_width  read addresses; port k uses bits [k*addr_width +: addr_width].
- D_OUT  out  n_rd*data_width  registered read data; port k uses bits [k*data_width +: data_width].
- CLR  in  1  one-cycle request to re-clear the whole array.
- BUSY  out  1  high while the clear sequencer owns the array.
- ERR_OOR  out  1  sticky flag: an out-of-range read or write address occurred.
- WDROP  out  1  sticky flag: a user write was dropped because BUSY was high.

## Operation
- Clear FSM has two states: CLEAR and IDLE. It holds a pointer ptr in the range lo..hi.
- RST high: next state CLEAR, ptr=lo. Reset values: BUSY=1, D_OUT all 0, ERR_OOR=0, WDROP=0.
- In CLEAR with RST low, each cycle:
  - write arr[ptr]=init_val;
  - if ptr==hi, next state IDLE; otherwise ptr+1.
- The clear takes exactly hi-lo+1 cycles.
- CLR in IDLE: next state CLEAR, ptr=lo. ERR_OOR and WDROP are cleared.
- CLR in CLEAR: ptr restarts at lo; the sequence is not shortened.
- WE while BUSY=1: the write is discarded and WDROP is set.
- WE while IDLE:
  - ADDR_IN in lo..hi: arr[ADDR_IN]<=D_IN;
  - otherwise the write is discarded and ERR_OOR is set.
- Read port k, each cycle:
  - BUSY=1: D_OUT[k] loads init_val;
  - ADDR_RD[k] out of range: D_OUT[k] loads init_val and ERR_OOR is set;
  - otherwise D_OUT[k] loads arr[ADDR_RD[k]], subject to the collision rule (Configuration).
- Address comparisons are unsigned at addr_width. There is no wrap-around: an index above hi is out of range, never folded.
- Writes and reads are 2-state; there are no X values in the array after the clear completes.

## Timing
- Read latency: 1 cycle. The address sampled at edge t gives D_OUT valid after edge t, held until edge t+1.
- Write latency: 1 cycle. Data written at edge t is visible to a read address sampled at edge t+1 in both configurations.
- BUSY rises the cycle after RST is sampled high. After RST falls, BUSY stays high for hi-lo+1 cycles; it falls the cycle after the ptr==hi write.
- Simultaneous CLR and WE in IDLE: CLR wins; the write is dropped and WDROP is set.
- Sticky flags update 1 cycle after the offending event. They clear only on RST or an accepted CLR; flag setting takes precedence in the same cycle.

## Configuration
- Macro REGFILE_BYPASS_EN.
- Defined: write-first. If WE is accepted and ADDR_IN==ADDR_RD[k] in the same cycle, D_OUT[k] loads D_IN.
- Undefined: read-first. D_OUT[k] loads the old arr contents.
- The clear sequencer and flags are identical in both configurations.

## Structure
- Package regfile_pkg holds:
  - state encoding constants ST_IDLE and ST_CLEAR;
  - the max read-port constant RF_MAX_RD=8;
  - a range-check function in_range(addr, lo, hi).
- Sub-module regfile_clr_fsm is the clear sequencer.
  - Inputs: CLK, RST, CLR.
  - Outputs: BUSY, clr_we, clr_addr.
  - Parameters: lo, hi, addr_width.
- The top level holds the array, the write mux (sequencer vs user), the n_rd read registers built by a generate loop, and the flags.

## Test plan
Bench configuration: lo=0, hi=15, data_width=8, n_rd=2, init_val=8'hAA.
- Reset clear: RST high 1 cycle, then low -> BUSY high exactly 16 cycles; afterwards reads of addresses 0..15 all return 8'hAA one cycle after the address is presented.
- Write then read: write 8'h3C to address 5, then ADDR_RD port 0=5 next cycle -> D_OUT port 0=8'h3C one cycle later. Port 1=6 -> 8'hAA.
- Collision: write 8'h77 to address 9 with port 0 reading 9 in the same cycle.
  - With REGFILE_BYPASS_EN -> D_OUT=8'h77.
  - Without it -> 8'hAA; 8'h77 on the next read.
- Dropped write: assert CLR, then WE=1 to address 2 with 8'h11 while BUSY=1 -> WDROP=1; after the clear, address 2 reads 8'hAA.
- Out of range: hi=12, write to address 14 -> no array change, ERR_OOR=1. A read of 13 -> D_OUT=8'hAA with ERR_OOR held. CLR -> ERR_OOR=0.
- Mid-clear reset: RST pulsed while ptr=7 -> the sequence restarts at 0 and BUSY stays high 16 more cycles after RST falls.
